cpu0_mem_arbiter: RTL and testbench

- Shares one single-port, byte-wide synchronous memory between two requesters of the CPU0 core: the instruction-fetch port (I) and the load/store/stack data port (D).
- Sequences each word access as 4 big-endian byte beats: byte at addr is the MSB.
- Sequences each byte access as 1 beat.
- Returns assembled read data with a one-cycle ack pulse. Replaces direct `m[]` indexing in the multi-cycle CPU0 variant.

---
 rtl/cpu0_mem_pkg.sv | 27 ++
 rtl/cpu0_mem_arbiter_if.sv | 37 +++
 rtl/cpu0_byte_sequencer.sv | 83 ++++++++
 rtl/cpu0_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_cpu0_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu0_mem_pkg.sv
// cpu0_mem_pkg: shared types and constants for the CPU0 memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, XFER, WAIT, RESP)
//   owner_e     : which requester owns the current access (OWN_I / OWN_D)
//   WORD_BEATS / BYTE_BEATS : byte beats per word / byte access
//   last_beat() : beat-counter value of the final beat for an access size
package cpu0_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int WORD_BEATS = 4;
  localparam int BYTE_BEATS = 1;

  function automatic logic [1:0] last_beat(input logic is_byte);
    return is_byte ? 2'(BYTE_BEATS - 1) : 2'(WORD_BEATS - 1);
  endfunction

endpackage

// File: rtl/cpu0_mem_arbiter_if.sv
// cpu0_mem_arbiter_if: bundles the fetch port (i_*), the data port (d_*)
// and the byte-wide memory port (mem_*) of the CPU0 memory arbiter.
//   modport slave  : the arbiter side (takes requests, drives acks and memory)
//   modport master : the requester/memory side (drives requests and mem_rdata)
interface cpu0_mem_arbiter_if #(
  parameter int AW = 8
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          i_ack;

  logic          d_req;
  logic          d_we;
  logic          d_byte;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cpu0_byte_sequencer.sv
// cpu0_byte_sequencer: beat bookkeeping for one arbitrated access.
//   clock, reset_n : clock and synchronous active-low reset (counter only)
//   load_i         : latch base_i / wdata_i and restart the beat counter
//   byte_i         : latched access size from the arbiter (1 = byte)
//   step_i         : advance to the next beat (one beat per XFER cycle)
//   cap_i          : shift rbyte_i into the read assembly register
//   last_o         : current beat is the final one of the access
//   addr_o         : base + beat count, wrapping modulo 2^AW
//   wbyte_o        : write byte for the current beat, MSB first
//   rword_o        : assembled read word including the byte on rbyte_i
module cpu0_byte_sequencer
  import cpu0_mem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic [31:0]   wdata_i,
  input  logic          byte_i,
  input  logic          step_i,
  input  logic          cap_i,
  input  logic [7:0]    rbyte_i,
  output logic          last_o,
  output logic [AW-1:0] addr_o,
  output logic [7:0]    wbyte_o,
  output logic [31:0]   rword_o
);

  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] base_q;
  logic [31:0]   wdata_q;
  logic [31:0]   asm_q;

  assign last_o = (cnt_q == last_beat(byte_i));
  // Natural AW-bit overflow gives the required address wrap.
  assign addr_o = base_q + {{(AW-2){1'b0}}, cnt_q};

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 2'd0;
    end else if (step_i) begin
      cnt_d = last_o ? 2'd0 : cnt_q + 2'd1;
    end
  end

  always_comb begin
    wbyte_o = wdata_q[7:0];
    if (!byte_i) begin
      case (cnt_q)
        2'd0:    wbyte_o = wdata_q[31:24];
        2'd1:    wbyte_o = wdata_q[23:16];
        2'd2:    wbyte_o = wdata_q[15:8];
        default: wbyte_o = wdata_q[7:0];
      endcase
    end
  end

  // The final byte is used straight off the memory bus, so the response
  // needs no extra cycle to shift it in first.
  assign rword_o = byte_i ? {24'h0, rbyte_i} : {asm_q[23:0], rbyte_i};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (load_i) begin
      base_q  <= base_i;
      wdata_q <= wdata_i;
    end
    if (cap_i) begin
      asm_q <= {asm_q[23:0], rbyte_i};
    end
  end

endmodule

// File: rtl/cpu0_mem_arbiter.sv
// cpu0_mem_arbiter: shares one byte-wide synchronous memory between the
// CPU0 instruction-fetch port (I) and data port (D). Word accesses take
// four big-endian beats, byte accesses one; every access finishes with a
// one-cycle ack on the owning port together with its read data.
//   clock   : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : cpu0_mem_arbiter_if.slave (i_*, d_*, mem_* signals)
// Build option: define CPU0_ARB_ROUND_ROBIN_EN to alternate grants on
// contention; otherwise D always beats I.
module cpu0_mem_arbiter
  import cpu0_mem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  cpu0_mem_arbiter_if.slave   bus
);

  arb_state_e    state_q;
  owner_e        owner_q;
  owner_e        grant_d;
  logic          we_q;
  logic          size_q;
  logic          cap_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_wdata_q;
  logic          i_ack_q, d_ack_q;
  logic [31:0]   i_rdata_q, d_rdata_q;

  logic          load_d;
  logic [AW-1:0] base_d;
  logic          seq_last;
  logic [AW-1:0] seq_addr;
  logic [7:0]    seq_wbyte;
  logic [31:0]   seq_rword;

`ifdef CPU0_ARB_ROUND_ROBIN_EN
  owner_e last_q;

  always_comb begin
    grant_d = OWN_I;
    if (bus.d_req && bus.i_req) begin
      grant_d = (last_q == OWN_D) ? OWN_I : OWN_D;
    end else if (bus.d_req) begin
      grant_d = OWN_D;
    end
  end
`else
  always_comb begin
    grant_d = bus.d_req ? OWN_D : OWN_I;
  end
`endif

  assign load_d = (state_q == IDLE) && (bus.i_req || bus.d_req);
  assign base_d = (grant_d == OWN_D) ? bus.d_addr : bus.i_addr;

  cpu0_byte_sequencer #(.AW(AW)) u_seq (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (load_d),
    .base_i  (base_d),
    .wdata_i (bus.d_wdata),
    .byte_i  (size_q),
    .step_i  (state_q == XFER),
    .cap_i   (cap_q),
    .rbyte_i (bus.mem_rdata),
    .last_o  (seq_last),
    .addr_o  (seq_addr),
    .wbyte_o (seq_wbyte),
    .rword_o (seq_rword)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      we_q        <= 1'b0;
      size_q      <= 1'b0;
      cap_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
`ifdef CPU0_ARB_ROUND_ROBIN_EN
      last_q      <= OWN_D;
`endif
    end else begin
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      // A read beat on the bus this cycle returns its byte next cycle.
      cap_q    <= mem_en_q & ~mem_we_q;
      case (state_q)
        IDLE: begin
          if (load_d) begin
            owner_q <= grant_d;
            we_q    <= (grant_d == OWN_D) & bus.d_we;
            size_q  <= (grant_d == OWN_D) & bus.d_byte;
            state_q <= XFER;
`ifdef CPU0_ARB_ROUND_ROBIN_EN
            last_q  <= grant_d;
`endif
          end
        end
        XFER: begin
          mem_en_q    <= 1'b1;
          mem_we_q    <= we_q;
          mem_addr_q  <= seq_addr;
          mem_wdata_q <= seq_wbyte;
          if (seq_last) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          state_q <= RESP;
        end
        RESP: begin
          // Stores leave the owner's rdata untouched: there is nothing to return.
          if (owner_q == OWN_D) begin
            d_ack_q <= 1'b1;
            if (!we_q) begin
              d_rdata_q <= seq_rword;
            end
          end else begin
            i_ack_q   <= 1'b1;
            i_rdata_q <= seq_rword;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// tb_cpu0_mem_arbiter: self-checking bench for cpu0_mem_arbiter with a
// behavioural byte memory, a table of single transactions and hand-written
// sequences for contention, address wrap, beat timing and mid-access reset.
module tb_cpu0_mem_arbiter;

  logic clock;
  logic reset_n;

  cpu0_mem_arbiter_if #(.AW(8)) bus ();

  cpu0_mem_arbiter #(.AW(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural memory, plus a preload port used while the DUT is idle.
  logic [7:0] mem [256];
  logic       pl_we;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clock) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    bit          is_d;
    bit          we;
    bit          bsz;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          is_d;
    bit          chk_data;
    logic [31:0] data;
    int          lat;
  } sb_t;

  sb_t  sbq [$];
  vec_t vecs [10];

  int checks = 0;
  int errors = 0;

  logic       en_hist   [32];
  logic       we_hist   [32];
  logic [7:0] addr_hist [32];
  logic [7:0] wd_hist   [32];

  function automatic vec_t mk(input bit is_d, input bit we, input bit bsz,
                              input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input int exp_lat);
    vec_t v;
    v.is_d = is_d; v.we = we; v.bsz = bsz; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_we = 1'b0;
  endtask

  // Call at a negedge; the following rising edge is cycle 0 of the access.
  task automatic drive(input vec_t v);
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_byte = v.bsz;
      bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end
  endtask

  task automatic issue(input vec_t v, input int lat);
    sb_t e;
    drive(v);
    e.is_d = v.is_d; e.chk_data = !v.we; e.data = v.exp_rdata; e.lat = lat;
    sbq.push_back(e);
  endtask

  task automatic take_ack(input bit from_d, input int n);
    sb_t e;
    if (sbq.size() == 0) begin
      chk("unexpected_ack", 32'(from_d), 32'hFFFF_FFFF);
      return;
    end
    e = sbq.pop_front();
    chk("ack_owner", 32'(from_d), 32'(e.is_d));
    chk("ack_latency", 32'(n), 32'(e.lat));
    if (e.chk_data) chk("ack_rdata", from_d ? bus.d_rdata : bus.i_rdata, e.data);
    if (from_d) bus.d_req = 1'b0;
    else        bus.i_req = 1'b0;
  endtask

  // Runs from cycle 0 until `want` acks arrive, recording the memory bus.
  task automatic run_until_acks(input int want);
    int got;
    got = 0;
    for (int k = 0; k < 32; k++) begin
      en_hist[k] = 1'b0; we_hist[k] = 1'b0; addr_hist[k] = 8'h00; wd_hist[k] = 8'h00;
    end
    @(posedge clock);
    for (int n = 0; n <= 25 && got < want; n++) begin
      if (n > 0) @(posedge clock);
      #1;
      en_hist[n] = bus.mem_en; we_hist[n] = bus.mem_we;
      addr_hist[n] = bus.mem_addr; wd_hist[n] = bus.mem_wdata;
      if (bus.d_ack) begin take_ack(1'b1, n); got++; end
      if (bus.i_ack) begin take_ack(1'b0, n); got++; end
    end
    if (got < want) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got %0d acks, expected %0d", got, want);
      sbq.delete();
      bus.d_req = 1'b0; bus.i_req = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] other;
    logic        ack_seen;
    vec_t        v;

    reset_n = 1'b0;
    pl_we = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    bus.i_req = 1'b0; bus.i_addr = 8'h00;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_byte = 1'b0;
    bus.d_addr = 8'h00; bus.d_wdata = 32'h0;
    bus.mem_rdata = 8'h00;

    vecs[0] = mk(1, 0, 0, 8'h10, 32'h0,        32'h1234_5678, 6);
    vecs[1] = mk(1, 0, 1, 8'h11, 32'h0,        32'h0000_0034, 3);
    vecs[2] = mk(1, 1, 0, 8'h20, 32'hDEAD_BEEF, 32'h0,        6);
    vecs[3] = mk(1, 0, 0, 8'h20, 32'h0,        32'hDEAD_BEEF, 6);
    vecs[4] = mk(1, 1, 1, 8'h21, 32'h1234_565A, 32'h0,        3);
    vecs[5] = mk(1, 0, 0, 8'h20, 32'h0,        32'hDE5A_BEEF, 6);
    vecs[6] = mk(0, 0, 0, 8'hFE, 32'h0,        32'hAABB_CCDD, 6);
    vecs[7] = mk(1, 0, 1, 8'hFF, 32'h0,        32'h0000_00BB, 3);
    vecs[8] = mk(0, 0, 0, 8'h10, 32'h0,        32'h1234_5678, 6);
    vecs[9] = mk(1, 0, 1, 8'h13, 32'h0,        32'h0000_0078, 3);

    // Memory preload happens under reset.
    poke(8'h10, 8'h12); poke(8'h11, 8'h34); poke(8'h12, 8'h56); poke(8'h13, 8'h78);
    poke(8'hFE, 8'hAA); poke(8'hFF, 8'hBB); poke(8'h00, 8'hCC); poke(8'h01, 8'hDD);
    poke(8'h30, 8'hFF); poke(8'h31, 8'hFF); poke(8'h32, 8'h77); poke(8'h33, 8'h88);

    @(posedge clock); #1;
    chk("rst_i_ack",     32'(bus.i_ack),     32'h0);
    chk("rst_d_ack",     32'(bus.d_ack),     32'h0);
    chk("rst_i_rdata",   bus.i_rdata,        32'h0);
    chk("rst_d_rdata",   bus.d_rdata,        32'h0);
    chk("rst_mem_en",    32'(bus.mem_en),    32'h0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'h0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single transactions; the idle port's rdata must not move.
    for (int t = 0; t < 10; t++) begin
      @(negedge clock);
      other = vecs[t].is_d ? bus.i_rdata : bus.d_rdata;
      issue(vecs[t], vecs[t].exp_lat);
      run_until_acks(1);
      chk("nonowner_rdata", vecs[t].is_d ? bus.i_rdata : bus.d_rdata, other);
    end

    // Byte load: exactly one beat, in cycle 1.
    @(negedge clock);
    issue(mk(1, 0, 1, 8'h12, 32'h0, 32'h0000_0056, 3), 3);
    run_until_acks(1);
    chk("byte_en_c0",   32'(en_hist[0]),   32'h0);
    chk("byte_en_c1",   32'(en_hist[1]),   32'h1);
    chk("byte_en_c2",   32'(en_hist[2]),   32'h0);
    chk("byte_addr_c1", 32'(addr_hist[1]), 32'h12);

    // Word store: MSB-first write beats in cycles 1-4.
    @(negedge clock);
    issue(mk(1, 1, 0, 8'h40, 32'hCAFE_F00D, 32'h0, 6), 6);
    run_until_acks(1);
    for (int c = 1; c <= 4; c++) begin
      chk("store_en",    32'(en_hist[c]),   32'h1);
      chk("store_we",    32'(we_hist[c]),   32'h1);
      chk("store_addr",  32'(addr_hist[c]), 32'h40 + 32'(c - 1));
    end
    chk("store_wd_c1", 32'(wd_hist[1]), 32'hCA);
    chk("store_wd_c2", 32'(wd_hist[2]), 32'hFE);
    chk("store_wd_c3", 32'(wd_hist[3]), 32'hF0);
    chk("store_wd_c4", 32'(wd_hist[4]), 32'h0D);
    chk("store_en_c5", 32'(en_hist[5]), 32'h0);
    chk("store_mem43", 32'(mem[8'h43]), 32'h0D);

    // Word fetch across the top of memory wraps to 0x00.
    @(negedge clock);
    issue(mk(0, 0, 0, 8'hFE, 32'h0, 32'hAABB_CCDD, 6), 6);
    run_until_acks(1);
    chk("wrap_addr_c1", 32'(addr_hist[1]), 32'hFE);
    chk("wrap_addr_c2", 32'(addr_hist[2]), 32'hFF);
    chk("wrap_addr_c3", 32'(addr_hist[3]), 32'h00);
    chk("wrap_addr_c4", 32'(addr_hist[4]), 32'h01);

    // Contention: D served first, I granted in the IDLE cycle after D's ack.
    @(negedge clock);
    issue(mk(1, 0, 0, 8'h20, 32'h0, 32'hDE5A_BEEF, 6), 6);
    issue(mk(0, 0, 0, 8'h40, 32'h0, 32'hCAFE_F00D, 13), 13);
    run_until_acks(2);

    // Reset in cycle 2 of a word store abandons it after two written bytes.
    @(negedge clock);
    v = mk(1, 1, 0, 8'h30, 32'h1122_3344, 32'h0, 6);
    drive(v);
    @(posedge clock);
    @(posedge clock); #1;
    chk("rst_mid_en_c1", 32'(bus.mem_en), 32'h1);
    @(posedge clock); #1;
    chk("rst_mid_en_c2", 32'(bus.mem_en), 32'h1);
    reset_n = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clock); #1;
    chk("rst_mid_en_c3",   32'(bus.mem_en),    32'h0);
    chk("rst_mid_we",      32'(bus.mem_we),    32'h0);
    chk("rst_mid_addr",    32'(bus.mem_addr),  32'h0);
    chk("rst_mid_wdata",   32'(bus.mem_wdata), 32'h0);
    chk("rst_mid_d_ack",   32'(bus.d_ack),     32'h0);
    chk("rst_mid_i_rdata", bus.i_rdata,        32'h0);
    chk("rst_mid_d_rdata", bus.d_rdata,        32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    ack_seen = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
      if (bus.d_ack || bus.i_ack) ack_seen = 1'b1;
    end
    chk("rst_mid_no_ack", 32'(ack_seen), 32'h0);
    chk("rst_mid_mem30", 32'(mem[8'h30]), 32'h11);
    chk("rst_mid_mem31", 32'(mem[8'h31]), 32'h22);
    chk("rst_mid_mem32", 32'(mem[8'h32]), 32'h77);
    chk("rst_mid_mem33", 32'(mem[8'h33]), 32'h88);

    @(negedge clock);
    issue(mk(0, 0, 0, 8'h10, 32'h0, 32'h1234_5678, 6), 6);
    run_until_acks(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
